// File: rtl/clock_tick_pkg.sv
// Shared constants and types for the slow-tap receiver: default widths,
// tap channel indices and the per-channel measurement state encoding.
package clock_tick_pkg;

    localparam int DEFAULT_N_CH        = 6;
    localparam int DEFAULT_CNT_W       = 28;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_TIMEOUT     = 2**28 - 1;
    localparam int SEL_W               = 3;

    // Tap positions on slow_in as wired from the clock divider
    localparam int CH_1HZ     = 0;
    localparam int CH_10HZ    = 1;
    localparam int CH_20HZ    = 2;
    localparam int CH_40HZ    = 3;
    localparam int CH_DIV8    = 4;
    localparam int CH_DIV2_18 = 5;

    // Measurement state of one channel:
    //   IDLE    - no edge seen since reset
    //   ARMED   - one edge seen, counter running, no period yet
    //   VALID   - period register holds a real measurement
    //   STALLED - armed channel went TIMEOUT cycles without an edge
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_VALID   = 2'd2,
        ST_STALLED = 2'd3
    } ch_state_t;

endpackage

// File: rtl/clock_tick_sync_if.sv
// Signal bundle between the slow-tap receiver and its consumer.
// There is no valid/ready handshake here: tick is a one-cycle strobe the
// consumer must use in the cycle it appears, and period_out/period_valid are
// a registered readout with one cycle of latency from period_sel.
// dbg_state exposes every channel's measurement state for observation.
interface clock_tick_sync_if #(
    parameter int N_CH  = clock_tick_pkg::DEFAULT_N_CH,
    parameter int CNT_W = clock_tick_pkg::DEFAULT_CNT_W
);
    logic [N_CH-1:0]                          slow_in;
    logic [N_CH-1:0]                          tick;
    logic [N_CH-1:0]                          level;
    logic [N_CH-1:0]                          stalled;
    logic [clock_tick_pkg::SEL_W-1:0]         period_sel;
    logic [CNT_W-1:0]                         period_out;
    logic                                     period_valid;
    clock_tick_pkg::ch_state_t [N_CH-1:0]     dbg_state;

    modport master (
        output slow_in, period_sel,
        input  tick, level, stalled, period_out, period_valid, dbg_state
    );

    modport slave (
        input  slow_in, period_sel,
        output tick, level, stalled, period_out, period_valid, dbg_state
    );
endinterface

// File: rtl/clock_tick_sync_tick_channel.sv
// One slow tap: synchronizer chain, rising-edge detect, period counter and
// the armed/valid/stalled tracking. All bookkeeping keys off the
// combinational rise so that tick, the counter restart and the period load
// land on the same clk edge.
module tick_channel #(
    parameter int SYNC_STAGES = clock_tick_pkg::DEFAULT_SYNC_STAGES,
    parameter int CNT_W       = clock_tick_pkg::DEFAULT_CNT_W,
    parameter int TIMEOUT     = clock_tick_pkg::DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      slow_in,
    output logic                      tick,
    output logic                      level,
    output logic                      stalled,
    output logic                      vld,
    output logic [CNT_W-1:0]          period,
    output clock_tick_pkg::ch_state_t state
);
    import clock_tick_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   rise;
    logic                   timeout;
    logic [CNT_W-1:0]       period_next;

    assign rise        = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign timeout     = (cnt_q == STALL_AT);
    assign period_next = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    assign level       = sync_q[SYNC_STAGES-1];

    // Synchronize the tap, remember the last synced level, register the edge strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            tick   <= rise;
        end
    end

    // Cycles since the last edge: restart on an edge, otherwise count and saturate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (rise) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Measurement FSM; an edge always beats a coincident timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            stalled <= 1'b0;
            vld     <= 1'b0;
            period  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (rise) begin
                        state  <= ST_VALID;
                        vld    <= 1'b1;
                        period <= period_next;
                    end else if (timeout) begin
                        state   <= ST_STALLED;
                        stalled <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (rise) begin
                        period <= period_next;
                    end else if (timeout) begin
                        state   <= ST_STALLED;
                        stalled <= 1'b1;
                        vld     <= 1'b0;
                    end
                end
                ST_STALLED: begin
                    if (rise) begin
                        state   <= ST_ARMED;
                        stalled <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    stalled <= 1'b0;
                    vld     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/clock_tick_sync.sv
// Receiver for the divided-clock taps: one tick_channel per tap plus a
// registered period readout selected by period_sel.
module clock_tick_sync #(
    parameter int N_CH        = clock_tick_pkg::DEFAULT_N_CH,
    parameter int SYNC_STAGES = clock_tick_pkg::DEFAULT_SYNC_STAGES,
    parameter int CNT_W       = clock_tick_pkg::DEFAULT_CNT_W,
    parameter int TIMEOUT     = clock_tick_pkg::DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    clock_tick_sync_if.slave   bus
);
    import clock_tick_pkg::*;

    logic [N_CH-1:0]        tick_w;
    logic [N_CH-1:0]        level_w;
    logic [N_CH-1:0]        stalled_w;
    logic [N_CH-1:0]        vld_w;
    logic [CNT_W-1:0]       period_w [N_CH];
    ch_state_t [N_CH-1:0]   state_w;
    logic [CNT_W-1:0]       period_out_q;
    logic                   period_valid_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .TIMEOUT     (TIMEOUT)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .slow_in (bus.slow_in[i]),
            .tick    (tick_w[i]),
            .level   (level_w[i]),
            .stalled (stalled_w[i]),
            .vld     (vld_w[i]),
            .period  (period_w[i]),
            .state   (state_w[i])
        );
    end

    // Registered readout; out-of-range selects read as an invalid zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_out_q   <= '0;
            period_valid_q <= 1'b0;
        end else if (int'(bus.period_sel) < N_CH) begin
            period_out_q   <= period_w[bus.period_sel];
            period_valid_q <= vld_w[bus.period_sel];
        end else begin
            period_out_q   <= '0;
            period_valid_q <= 1'b0;
        end
    end

    assign bus.tick         = tick_w;
    assign bus.level        = level_w;
    assign bus.stalled      = stalled_w;
    assign bus.period_out   = period_out_q;
    assign bus.period_valid = period_valid_q;
    assign bus.dbg_state    = state_w;

endmodule

// File: tb/tb_clock_tick_sync.sv
// Bench for clock_tick_sync with CNT_W=8, TIMEOUT=40, SYNC_STAGES=2.
// The reference model works on edge timestamps: a tap rise sampled at edge k
// is a tick at edge k+2, periods are differences of tick timestamps and a
// stall is TIMEOUT edges after the last tick of an armed channel.
module tb_clock_tick_sync;
    import clock_tick_pkg::*;

    localparam int NC = 6;
    localparam int CW = 8;
    localparam int TO = 40;
    localparam int SS = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    clock_tick_sync_if #(.N_CH(NC), .CNT_W(CW)) bus ();

    clock_tick_sync #(
        .N_CH(NC), .SYNC_STAGES(SS), .CNT_W(CW), .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [NC-1:0] samp_q[$];
    int            m_edge;
    int            m_last [NC];
    bit            m_arm  [NC];
    bit            m_vld  [NC];
    bit            m_stl  [NC];
    int            m_per  [NC];
    logic [NC-1:0] e_tick, e_level, e_stl;
    logic [CW-1:0] e_po;
    logic          e_pv;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_edge);
        end
    endfunction

    function automatic void model_reset();
        samp_q.delete();
        for (int i = 0; i < 4; i++) samp_q.push_back('0);
        m_edge = 0;
        for (int i = 0; i < NC; i++) begin
            m_last[i] = 0; m_arm[i] = 0; m_vld[i] = 0; m_stl[i] = 0; m_per[i] = 0;
        end
        e_tick = '0; e_level = '0; e_stl = '0; e_po = '0; e_pv = 1'b0;
    endfunction

    function automatic void model_edge(input logic [NC-1:0] in, input logic [2:0] sel);
        int d;
        m_edge++;
        samp_q.push_front(in);
        void'(samp_q.pop_back());
        e_tick  = samp_q[2] & ~samp_q[3];
        e_level = samp_q[1];
        if (int'(sel) < NC) begin
            e_po = CW'(m_per[sel]);
            e_pv = m_vld[sel];
        end else begin
            e_po = '0;
            e_pv = 1'b0;
        end
        for (int i = 0; i < NC; i++) begin
            if (e_tick[i]) begin
                if (m_arm[i]) begin
                    d = m_edge - m_last[i];
                    m_per[i] = (d > 255) ? 255 : d;
                    m_vld[i] = 1;
                end
                m_arm[i]  = 1;
                m_stl[i]  = 0;
                m_last[i] = m_edge;
            end else if (m_arm[i] && (m_edge - m_last[i] == TO)) begin
                m_stl[i] = 1;
                m_arm[i] = 0;
                m_vld[i] = 0;
            end
            e_stl[i] = m_stl[i];
        end
    endfunction

    // ---------------- scoreboard compare ----------------
    task automatic check_all();
        ch_state_t es;
        chk("tick", 32'(bus.tick), 32'(e_tick));
        chk("level", 32'(bus.level), 32'(e_level));
        chk("stalled", 32'(bus.stalled), 32'(e_stl));
        chk("period_out", 32'(bus.period_out), 32'(e_po));
        chk("period_valid", 32'(bus.period_valid), 32'(e_pv));
        for (int i = 0; i < NC; i++) begin
            es = m_stl[i] ? ST_STALLED : m_vld[i] ? ST_VALID : m_arm[i] ? ST_ARMED : ST_IDLE;
            chk($sformatf("state%0d", i), 32'(bus.dbg_state[i]), 32'(es));
        end
    endtask

    // ---------------- driver tasks (start and end at a negedge) ----------------
    task automatic step(input logic [NC-1:0] in, input logic [2:0] sel);
        bus.slow_in    = in;
        bus.period_sel = sel;
        @(posedge clk);
        model_edge(in, sel);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [NC-1:0] in);
        reset          = 1'b1;
        bus.slow_in    = in;
        bus.period_sel = '0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [NC-1:0] wave(input int c, input int half, input int ch);
        logic [NC-1:0] v;
        v = '0;
        v[ch] = ((c % (2 * half)) < half);
        return v;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [NC-1:0] in;
        logic [NC-1:0] tick;
        logic [NC-1:0] level;
        logic [CW-1:0] po;
        logic          pv;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1000000;
        $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            ntick, t2, pv_rise, first_t, stall_e, last_t, drop_e, r1, r2, f;
        logic [NC-1:0] cur;
        int            lim [NC];

        tbl[0]  = '{6'h3F, 6'h00, 6'h00, 8'd0, 1'b0};
        tbl[1]  = '{6'h3F, 6'h00, 6'h3F, 8'd0, 1'b0};
        tbl[2]  = '{6'h3F, 6'h3F, 6'h3F, 8'd0, 1'b0};
        tbl[3]  = '{6'h00, 6'h00, 6'h3F, 8'd0, 1'b0};
        tbl[4]  = '{6'h00, 6'h00, 6'h00, 8'd0, 1'b0};
        tbl[5]  = '{6'h15, 6'h00, 6'h00, 8'd0, 1'b0};
        tbl[6]  = '{6'h2A, 6'h00, 6'h15, 8'd0, 1'b0};
        tbl[7]  = '{6'h3F, 6'h15, 6'h2A, 8'd0, 1'b0};
        tbl[8]  = '{6'h00, 6'h2A, 6'h3F, 8'd5, 1'b1};
        tbl[9]  = '{6'h00, 6'h15, 6'h00, 8'd5, 1'b1};
        tbl[10] = '{6'h00, 6'h00, 6'h00, 8'd2, 1'b1};
        lim = '{1, 3, 6, 12, 30, 60};

        reset          = 1'b1;
        bus.slow_in    = '0;
        bus.period_sel = '0;
        model_reset();
        @(negedge clk);

        // All-channel simultaneous edges and staggered patterns
        do_reset('0);
        for (int e = 0; e < 11; e++) begin
            step(tbl[e].in, 3'd0);
            chk($sformatf("tbl%0d_tick", e), 32'(bus.tick), 32'(tbl[e].tick));
            chk($sformatf("tbl%0d_level", e), 32'(bus.level), 32'(tbl[e].level));
            chk($sformatf("tbl%0d_po", e), 32'(bus.period_out), 32'(tbl[e].po));
            chk($sformatf("tbl%0d_pv", e), 32'(bus.period_valid), 32'(tbl[e].pv));
        end

        // ch0 square wave, period 16
        do_reset('0);
        ntick = 0; t2 = -1; pv_rise = -1;
        for (int c = 0; c < 64; c++) begin
            step(wave(c, 8, CH_1HZ), 3'd0);
            if (c % 16 == 2) chk("t1_tick_at_rise_plus2", 32'(bus.tick[0]), 32'd1);
            if (bus.tick[0]) begin
                ntick++;
                if (ntick == 2) t2 = m_edge;
            end
            if (bus.period_valid && pv_rise < 0) pv_rise = m_edge;
        end
        chk("t1_valid_latency", 32'(pv_rise - t2), 32'd1);
        chk("t1_period", 32'(bus.period_out), 32'd16);
        chk("t1_valid", 32'(bus.period_valid), 32'd1);

        // Out-of-range selects, then back to channel 0
        step('0, 3'd6);
        chk("t6_sel6_po", 32'(bus.period_out), 32'd0);
        chk("t6_sel6_pv", 32'(bus.period_valid), 32'd0);
        step('0, 3'd7);
        chk("t6_sel7_po", 32'(bus.period_out), 32'd0);
        chk("t6_sel7_pv", 32'(bus.period_valid), 32'd0);
        step('0, 3'd0);
        chk("t6_sel0_po", 32'(bus.period_out), 32'd16);
        chk("t6_sel0_pv", 32'(bus.period_valid), 32'd1);

        // ch1 held high through reset release
        do_reset(6'b000010);
        ntick = 0; first_t = -1; stall_e = -1;
        for (int c = 0; c < 60; c++) begin
            step(6'b000010, 3'd1);
            if (bus.tick[1]) begin
                ntick++;
                if (first_t < 0) first_t = m_edge;
            end
            if (bus.stalled[1] && stall_e < 0) stall_e = m_edge;
        end
        chk("t2_tick_count", 32'(ntick), 32'd1);
        chk("t2_tick_edge", 32'(first_t), 32'(1 + SS));
        chk("t2_stall_delay", 32'(stall_e - first_t), 32'(TO));
        chk("t2_pv", 32'(bus.period_valid), 32'd0);

        // ch2 period 10, freeze, resume
        do_reset('0);
        last_t = -1; stall_e = -1; drop_e = -1;
        for (int c = 0; c < 50; c++) begin
            step(wave(c, 5, CH_20HZ), 3'd2);
            if (bus.tick[2]) last_t = m_edge;
        end
        chk("t3_pv_running", 32'(bus.period_valid), 32'd1);
        chk("t3_po_running", 32'(bus.period_out), 32'd10);
        for (int c = 0; c < 50; c++) begin
            step('0, 3'd2);
            if (bus.stalled[2] && stall_e < 0) stall_e = m_edge;
            if (!bus.period_valid && drop_e < 0) drop_e = m_edge;
        end
        chk("t3_stall_delay", 32'(stall_e - last_t), 32'(TO));
        chk("t3_valid_drop", 32'(drop_e - stall_e), 32'd1);
        chk("t3_stalled_held", 32'(bus.stalled[2]), 32'd1);
        r1 = -1; r2 = -1; pv_rise = -1;
        for (int c = 0; c < 30; c++) begin
            step(wave(c, 5, CH_20HZ), 3'd2);
            if (bus.tick[2]) begin
                if (r1 < 0) begin
                    r1 = m_edge;
                    chk("t3_stall_clear", 32'(bus.stalled[2]), 32'd0);
                end else if (r2 < 0) begin
                    r2 = m_edge;
                end
            end
            if (bus.period_valid && pv_rise < 0) pv_rise = m_edge;
        end
        chk("t3_resume_valid_latency", 32'(pv_rise - r2), 32'd1);
        chk("t3_resume_period", 32'(bus.period_out), 32'd10);

        // Reset mid-count on ch0 (cnt = 7)
        do_reset('0);
        f = 0;
        cur = '0;
        for (int c = 0; c < 40 && f == 0; c++) begin
            cur = wave(c, 8, CH_1HZ);
            step(cur, 3'd0);
            if (bus.tick[0]) f = c + 1;
        end
        chk("t5_first_tick_seen", 32'(f > 0), 32'd1);
        for (int c = f; c < f + 7; c++) begin
            cur = wave(c, 8, CH_1HZ);
            step(cur, 3'd0);
        end
        do_reset(cur);
        f = 0;
        for (int c = 0; c < 40; c++) begin
            step(wave(c, 8, CH_1HZ), 3'd0);
            if (f == 1) begin
                chk("t5_no_valid_first_tick", 32'(bus.period_valid), 32'd0);
                f = 2;
            end
            if (bus.tick[0] && f == 0) f = 1;
        end
        chk("t5_first_tick_checked", 32'(f), 32'd2);

        // Randomized taps and selects, with one reset in the middle
        do_reset('0);
        cur = '0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset(cur);
            for (int i = 0; i < NC; i++)
                if ($urandom_range(0, lim[i]) == 0) cur[i] = ~cur[i];
            step(cur, 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
